// File: rtl/bram_readback_checker_pkg.sv
// Shared definitions for the BRAM readback checker and its companion write-side FSM.
package bram_readback_checker_pkg;

    localparam int unsigned RB_ADDR_WIDTH = 9;
    localparam int unsigned RB_DATA_WIDTH = 16;
    localparam int unsigned RB_ERR_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rb_state_t;

    // Test pattern: the word stored at sweep index idx is seed + idx, wrapping at the word width.
    function automatic logic [RB_DATA_WIDTH-1:0] exp_word(
        input logic [RB_DATA_WIDTH-1:0] seed,
        input logic [RB_ADDR_WIDTH-1:0] idx
    );
        return seed + RB_DATA_WIDTH'(idx);
    endfunction

endpackage

// File: rtl/bram_readback_checker_cmp.sv
// Compare stage: counts mismatches (saturating), latches the first failing address
// and keeps the most recent word read.
module bram_readback_checker_cmp
    import bram_readback_checker_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RB_DATA_WIDTH,
    parameter int unsigned ERR_WIDTH  = RB_ERR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_expected,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_mismatch_c,
    output logic [ERR_WIDTH-1:0]  o_err_count,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr,
    output logic [DATA_WIDTH-1:0] o_last_value
);

    logic [ERR_WIDTH-1:0]  r_err_count;
    logic [ADDR_WIDTH-1:0] r_first_err_addr;
    logic [DATA_WIDTH-1:0] r_last_value;
    logic                  r_seen_err;
    logic                  w_mismatch;

    assign w_mismatch       = i_valid && (i_data != i_expected);
    assign o_mismatch_c     = w_mismatch;
    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;
    assign o_last_value     = r_last_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_last_value     <= '0;
            r_seen_err       <= 1'b0;
        end else if (i_clear) begin
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_seen_err       <= 1'b0;
        end else if (i_valid) begin
            r_last_value <= i_data;
            if (w_mismatch) begin
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + ERR_WIDTH'(1);
                end
                // Address 0 is a legal failing address, so a flag marks the capture.
                if (!r_seen_err) begin
                    r_seen_err       <= 1'b1;
                    r_first_err_addr <= i_addr;
                end
            end
        end
    end

endmodule

// File: rtl/bram_readback_checker.sv
// Port-B sweep sequencer: issues one read per cycle over a wrapping region and feeds
// each returned word, with its expected pattern value, to the compare stage.
module bram_readback_checker
    import bram_readback_checker_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RB_DATA_WIDTH,
    parameter int unsigned ERR_WIDTH  = RB_ERR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  en_b,
    output logic                  we_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] din_b,
    input  logic [DATA_WIDTH-1:0] dout_b,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] last_value
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    rb_state_t             r_state;
    logic                  r_en_b;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [CNT_WIDTH-1:0]  r_left;
    logic [DATA_WIDTH-1:0] r_seed;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_pipe_valid;
    logic [ADDR_WIDTH-1:0] r_pipe_idx;
    logic [ADDR_WIDTH-1:0] r_pipe_addr;

    logic                  w_accept;
    logic [CNT_WIDTH-1:0]  w_count_clamped;
    logic [DATA_WIDTH-1:0] w_expected;
    logic                  w_mismatch;
    logic [ERR_WIDTH-1:0]  w_err_count;

    // busy stays high through the done cycle, which also blocks a start landing on it.
    assign w_accept        = start && (r_state == ST_IDLE) && !r_busy;
    assign w_count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
    assign w_expected      = DATA_WIDTH'(exp_word(RB_DATA_WIDTH'(r_seed), RB_ADDR_WIDTH'(r_pipe_idx)));

    assign en_b   = r_en_b;
    assign we_b   = 1'b0;
    assign addr_b = r_addr_b;
    assign din_b  = '0;
    assign busy   = r_busy;
    assign done   = r_done;
    assign pass   = r_pass;
    assign err_count = w_err_count;

    // The last issue is registered on the transition into DRAIN; r_left counts issues still owed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_en_b       <= 1'b0;
            r_addr_b     <= '0;
            r_idx        <= '0;
            r_left       <= '0;
            r_seed       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_pipe_valid <= 1'b0;
            r_pipe_idx   <= '0;
            r_pipe_addr  <= '0;
        end else begin
            r_done       <= 1'b0;
            r_pipe_valid <= r_en_b;
            r_pipe_idx   <= r_idx;
            r_pipe_addr  <= r_addr_b;
            if (r_done) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        r_pass <= 1'b0;
                        r_seed <= seed;
                        r_idx  <= '0;
                        if (w_count_clamped == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_en_b   <= 1'b1;
                            r_addr_b <= base_addr;
                            r_left   <= w_count_clamped - CNT_WIDTH'(1);
                            r_state  <= (w_count_clamped == CNT_WIDTH'(1)) ? ST_DRAIN : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_addr_b <= r_addr_b + ADDR_WIDTH'(1);
                    r_idx    <= r_idx + ADDR_WIDTH'(1);
                    r_left   <= r_left - CNT_WIDTH'(1);
                    if (r_left == CNT_WIDTH'(1)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_en_b  <= 1'b0;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // The final word is compared on this same edge, so fold it into pass.
                    r_done  <= 1'b1;
                    r_pass  <= (w_err_count == '0) && !w_mismatch;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    bram_readback_checker_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ERR_WIDTH  (ERR_WIDTH)
    ) u_readback_cmp (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_clear          (w_accept),
        .i_valid          (r_pipe_valid),
        .i_expected       (w_expected),
        .i_data           (dout_b),
        .i_addr           (r_pipe_addr),
        .o_mismatch_c     (w_mismatch),
        .o_err_count      (w_err_count),
        .o_first_err_addr (first_err_addr),
        .o_last_value     (last_value)
    );

endmodule

// File: tb/tb_bram_readback_checker.sv
// Randomized bench for bram_readback_checker: a BRAM model on port B and a
// sweep-level reference model that derives every expected result from memory contents.
module tb_bram_readback_checker;

    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int EW    = 8;
    localparam int DEPTH = 512;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic [DW-1:0] seed;
    logic          en_b;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b;
    logic [DW-1:0] dout_b;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] last_value;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] model_last;
    int            checks;
    int            failures;

    bram_readback_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .count          (count),
        .seed           (seed),
        .en_b           (en_b),
        .we_b           (we_b),
        .addr_b         (addr_b),
        .din_b          (din_b),
        .dout_b         (dout_b),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .last_value     (last_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read BRAM port B: data appears the cycle after en_b.
    always @(posedge clk) begin
        if (en_b) dout_b <= mem[addr_b];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int base, input int cnt, input int sd);
        for (int i = 0; i < cnt; i++) mem[(base + i) % DEPTH] = DW'(sd + i);
    endtask

    task automatic run_sweep(input int base, input int cnt_in, input int sd,
                             input bit busy_start, input bit done_start);
        int            cnt, errs, first, en_seen, addr_bad, done_cyc, done_n, first_en;
        bit            seen;
        logic          d_pass, d_busy;
        logic [EW-1:0] d_err;
        logic [AW-1:0] d_first;
        logic [DW-1:0] d_last;
        cnt   = (cnt_in > DEPTH) ? DEPTH : cnt_in;
        errs  = 0;
        first = 0;
        seen  = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            if (mem[(base + i) % DEPTH] !== DW'(sd + i)) begin
                errs++;
                if (!seen) begin
                    seen  = 1'b1;
                    first = (base + i) % DEPTH;
                end
            end
        end
        if (errs > 255) errs = 255;
        if (cnt > 0) model_last = mem[(base + cnt - 1) % DEPTH];

        base_addr = AW'(base);
        count     = (AW+1)'(cnt_in);
        seed      = DW'(sd);
        start     = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        en_seen  = 0;
        addr_bad = 0;
        done_cyc = -1;
        done_n   = 0;
        first_en = -1;
        d_pass = 1'b0; d_busy = 1'b0; d_err = '0; d_first = '0; d_last = '0;
        for (int c = 1; c <= cnt + 8; c++) begin
            if (en_b) begin
                if (addr_b !== AW'((base + en_seen) % DEPTH)) addr_bad++;
                if (first_en < 0) first_en = c;
                en_seen++;
            end
            if (done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    d_pass = pass; d_busy = busy; d_err = err_count;
                    d_first = first_err_addr; d_last = last_value;
                end
            end
            if (c == 1) check_eq("busy_cycle1", 32'(busy), 32'd1);
            if (c == cnt + 3) check_eq("busy_after_done", 32'(busy), 32'd0);
            start = (busy_start && c == 2) || (done_start && c == done_cyc);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq("en_count", 32'(en_seen), 32'(cnt));
        check_eq("addr_seq_bad", 32'(addr_bad), 32'd0);
        if (cnt > 0) check_eq("first_en_cycle", 32'(first_en), 32'd1);
        check_eq("done_cycle", 32'(done_cyc), 32'(cnt + 2));
        check_eq("done_pulses", 32'(done_n), 32'd1);
        check_eq("busy_in_done", 32'(d_busy), 32'd1);
        check_eq("pass", 32'(d_pass), 32'(errs == 0));
        check_eq("err_count", 32'(d_err), 32'(errs));
        check_eq("first_err_addr", 32'(d_first), 32'(first));
        check_eq("last_value", 32'(d_last), 32'(model_last));
        check_eq("pass_held", 32'(pass), 32'(errs == 0));
    endtask

    task automatic reset_mid_sweep();
        int dn;
        fill(0, DEPTH, 16'h2000);
        for (int a = 10; a <= 12; a++) mem[a] = ~mem[a];
        base_addr = '0;
        count     = 10'd512;
        seed      = 16'h2000;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check_eq("pre_rst_en", 32'(en_b), 32'd1);
        check_eq("pre_rst_err", 32'(err_count), 32'd3);
        check_eq("pre_rst_first", 32'(first_err_addr), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_en_b", 32'(en_b), 32'd0);
        check_eq("rst_addr_b", 32'(addr_b), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_pass", 32'(pass), 32'd0);
        check_eq("rst_err", 32'(err_count), 32'd0);
        check_eq("rst_first", 32'(first_err_addr), 32'd0);
        check_eq("rst_last", 32'(last_value), 32'd0);
        model_last = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        dn = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (done || en_b) dn++;
        end
        check_eq("no_done_after_rst", 32'(dn), 32'd0);
    endtask

    initial begin
        int base, cnt, sd, ncorrupt, sel;
        checks     = 0;
        failures   = 0;
        model_last = '0;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        count      = '0;
        seed       = '0;
        for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_en_b", 32'(en_b), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_pass", 32'(pass), 32'd0);
        check_eq("reset_err", 32'(err_count), 32'd0);
        check_eq("reset_first", 32'(first_err_addr), 32'd0);
        check_eq("reset_last", 32'(last_value), 32'd0);
        check_eq("we_b_tied", 32'(we_b), 32'd0);
        check_eq("din_b_tied", 32'(din_b), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full clean sweep, then two corrupted words.
        fill(0, DEPTH, 16'h1000);
        run_sweep(0, 512, 16'h1000, 1'b0, 1'b0);
        check_eq("full_last_11ff", 32'(last_value), 32'h11FF);
        mem[37]  = mem[37] ^ 16'h0001;
        mem[200] = 16'h0000;
        run_sweep(0, 512, 16'h1000, 1'b0, 1'b0);
        check_eq("two_err_first37", 32'(first_err_addr), 32'd37);

        // Address and data wrap.
        fill(510, 4, 16'hFFFE);
        run_sweep(510, 4, 16'hFFFE, 1'b0, 1'b0);
        check_eq("wrap_last_0001", 32'(last_value), 32'h0001);

        // Empty sweep and ignored starts while busy or on the done cycle.
        run_sweep(100, 0, 16'h1234, 1'b1, 1'b1);
        fill(300, 20, 16'h0BAD);
        run_sweep(300, 20, 16'h0BAD, 1'b1, 1'b1);
        run_sweep(300, 1, 16'h0BAD, 1'b0, 1'b1);

        // Every word wrong: counter saturates.
        for (int i = 0; i < DEPTH; i++) mem[(7 + i) % DEPTH] = ~DW'(16'h1000 + i);
        run_sweep(7, 512, 16'h1000, 1'b0, 1'b0);

        reset_mid_sweep();
        fill(40, 64, 16'h55AA);
        run_sweep(40, 64, 16'h55AA, 1'b0, 1'b0);

        // Random regions, seeds, corruptions, and over-range counts.
        for (int k = 0; k < 12; k++) begin
            base = int'($urandom_range(0, DEPTH - 1));
            sd   = int'($urandom_range(0, 65535));
            sel  = int'($urandom_range(0, 7));
            if (sel == 0)      cnt = 0;
            else if (sel == 1) cnt = int'($urandom_range(513, 1023));
            else               cnt = int'($urandom_range(1, 120));
            for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom);
            fill(base, (cnt > DEPTH) ? DEPTH : cnt, sd);
            ncorrupt = (cnt == 0) ? 0 : int'($urandom_range(0, 3));
            for (int j = 0; j < ncorrupt; j++) begin
                int off;
                off = int'($urandom_range(0, ((cnt > DEPTH) ? DEPTH : cnt) - 1));
                mem[(base + off) % DEPTH] = mem[(base + off) % DEPTH] ^ DW'($urandom_range(1, 65535));
            end
            run_sweep(base, cnt, sd, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog: got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
